ps2_keyboard: RTL

PS2_KEYBOARD -- requirements
Module: ps2_keyboard

---
 rtl/ps2_pkg.sv | 85 ++++++++
 rtl/ps2_ascii_fifo.sv | 56 +++++
 rtl/ps2_keyboard.sv | 243 ++++++++++++++++++++++++
 3 files changed

// File: rtl/ps2_pkg.sv
// Shared PS/2 scan-code constants, receiver/decoder state types and the
// set-2 scan code to ASCII map used by the keyboard front end.
package ps2_pkg;

    localparam int ASCII_W = 8;

    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_SHIFT,
        RX_CHECK
    } rx_state_t;

    typedef enum logic [1:0] {
        D_NORM,
        D_BREAK,
        D_EXT,
        D_EXT_BREAK
    } dec_state_t;

    typedef struct packed {
        logic                 valid;
        logic [ASCII_W-1:0]   ascii;
    } ascii_map_t;

    // Letters are resolved to an alphabet index first so shift only picks the base.
    function automatic ascii_map_t scan_to_ascii(input logic [7:0] code, input logic shift);
        ascii_map_t m;
        logic       is_letter;
        logic [4:0] idx;
        m         = '0;
        is_letter = 1'b0;
        idx       = '0;
        case (code)
            8'h1C: begin is_letter = 1'b1; idx = 5'd0;  end
            8'h32: begin is_letter = 1'b1; idx = 5'd1;  end
            8'h21: begin is_letter = 1'b1; idx = 5'd2;  end
            8'h23: begin is_letter = 1'b1; idx = 5'd3;  end
            8'h24: begin is_letter = 1'b1; idx = 5'd4;  end
            8'h2B: begin is_letter = 1'b1; idx = 5'd5;  end
            8'h34: begin is_letter = 1'b1; idx = 5'd6;  end
            8'h33: begin is_letter = 1'b1; idx = 5'd7;  end
            8'h43: begin is_letter = 1'b1; idx = 5'd8;  end
            8'h3B: begin is_letter = 1'b1; idx = 5'd9;  end
            8'h42: begin is_letter = 1'b1; idx = 5'd10; end
            8'h4B: begin is_letter = 1'b1; idx = 5'd11; end
            8'h3A: begin is_letter = 1'b1; idx = 5'd12; end
            8'h31: begin is_letter = 1'b1; idx = 5'd13; end
            8'h44: begin is_letter = 1'b1; idx = 5'd14; end
            8'h4D: begin is_letter = 1'b1; idx = 5'd15; end
            8'h15: begin is_letter = 1'b1; idx = 5'd16; end
            8'h2D: begin is_letter = 1'b1; idx = 5'd17; end
            8'h1B: begin is_letter = 1'b1; idx = 5'd18; end
            8'h2C: begin is_letter = 1'b1; idx = 5'd19; end
            8'h3C: begin is_letter = 1'b1; idx = 5'd20; end
            8'h2A: begin is_letter = 1'b1; idx = 5'd21; end
            8'h1D: begin is_letter = 1'b1; idx = 5'd22; end
            8'h22: begin is_letter = 1'b1; idx = 5'd23; end
            8'h35: begin is_letter = 1'b1; idx = 5'd24; end
            8'h1A: begin is_letter = 1'b1; idx = 5'd25; end
            8'h45: begin m.valid = 1'b1; m.ascii = 8'h30; end
            8'h16: begin m.valid = 1'b1; m.ascii = 8'h31; end
            8'h1E: begin m.valid = 1'b1; m.ascii = 8'h32; end
            8'h26: begin m.valid = 1'b1; m.ascii = 8'h33; end
            8'h25: begin m.valid = 1'b1; m.ascii = 8'h34; end
            8'h2E: begin m.valid = 1'b1; m.ascii = 8'h35; end
            8'h36: begin m.valid = 1'b1; m.ascii = 8'h36; end
            8'h3D: begin m.valid = 1'b1; m.ascii = 8'h37; end
            8'h3E: begin m.valid = 1'b1; m.ascii = 8'h38; end
            8'h46: begin m.valid = 1'b1; m.ascii = 8'h39; end
            8'h29: begin m.valid = 1'b1; m.ascii = 8'h20; end
            default: m = '0;
        endcase
        if (is_letter) begin
            m.valid = 1'b1;
            m.ascii = (shift ? 8'h41 : 8'h61) + {3'b000, idx};
        end
        return m;
    endfunction

endpackage

// File: rtl/ps2_ascii_fifo.sv
// Small ASCII character FIFO with a ready/valid read side; drops writes when
// full unless a pop happens in the same cycle.
module ps2_ascii_fifo
    import ps2_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               wr_en,
    input  logic [ASCII_W-1:0] wr_data,
    output logic [ASCII_W-1:0] rd_data,
    output logic               rd_valid,
    input  logic               rd_ready,
    output logic               overflow
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

    logic [ASCII_W-1:0] mem_q [DEPTH];
    logic [AW:0]        wr_ptr_q, wr_ptr_d;
    logic [AW:0]        rd_ptr_q, rd_ptr_d;
    logic               full;
    logic               pop;
    logic               push_ok;

    // Pointers carry one extra MSB so full and empty differ only in that bit.
    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        rd_valid = (wr_ptr_q != rd_ptr_q);
        pop      = rd_valid && rd_ready;
        push_ok  = wr_en && (!full || pop);
        overflow = wr_en && full && !pop;
        rd_data  = rd_valid ? mem_q[rd_ptr_q[AW-1:0]] : '0;
        wr_ptr_d = push_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
        rd_ptr_d = pop ? rd_ptr_q + PTR_ONE : rd_ptr_q;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_ptr_q[AW-1:0]] <= wr_data;
        end
    end

endmodule

// File: rtl/ps2_keyboard.sv
// PS/2 keyboard receiver, set-2 decoder and ASCII FIFO front end.
// Optional build macro PS2_REPEAT_FILTER_EN drops typematic repeats of a held key.
//
// state       | meaning
// RX_IDLE     | waiting for a start bit (falling ps2_clk with data low)
// RX_SHIFT    | shifting 8 data bits, parity and stop; timeout armed
// RX_CHECK    | one cycle: validate frame, run decoder, write FIFO
// D_NORM      | next byte is a make code or a prefix
// D_BREAK     | next byte is a released key
// D_EXT       | extended prefix seen, next byte ignored
// D_EXT_BREAK | extended release, next byte ignored
module ps2_keyboard
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               ps2_clk,
    input  logic               ps2_data,
    output logic [ASCII_W-1:0] key_ascii,
    output logic               key_valid,
    input  logic               key_ready,
    output logic               overflow,
    output logic               frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TIMER_LOAD = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] TIMER_ONE  = TW'(1);

    logic ps2_clk_s1_q, ps2_clk_s2_q, ps2_clk_s3_q;
    logic ps2_data_s1_q, ps2_data_s2_q;
    logic ps2_fall;

    rx_state_t     rx_state_q, rx_state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [9:0]    frame_q, frame_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          frame_ok;
    logic          rx_err;

    dec_state_t    dec_state_q, dec_state_d;
    logic          shift_flag_q, shift_flag_d;
    logic [7:0]    rx_byte;
    logic          is_make;
    logic          is_release;
    logic          is_shift_code;
    logic          repeat_hit;
    ascii_map_t    map;
    logic          wr_en;
    logic [7:0]    wr_data;

    logic          fifo_ovf;
    logic          overflow_q, overflow_d;
    logic          frame_err_q, frame_err_d;

    // Idle-high reset values keep the edge detector quiet coming out of reset.
    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            ps2_clk_s1_q  <= 1'b1;
            ps2_clk_s2_q  <= 1'b1;
            ps2_clk_s3_q  <= 1'b1;
            ps2_data_s1_q <= 1'b1;
            ps2_data_s2_q <= 1'b1;
        end else begin
            ps2_clk_s1_q  <= ps2_clk;
            ps2_clk_s2_q  <= ps2_clk_s1_q;
            ps2_clk_s3_q  <= ps2_clk_s2_q;
            ps2_data_s1_q <= ps2_data;
            ps2_data_s2_q <= ps2_data_s1_q;
        end
    end

    assign ps2_fall = ps2_clk_s3_q && !ps2_clk_s2_q;

    always_comb begin
        rx_state_d = rx_state_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        timer_d    = timer_q;
        frame_ok   = 1'b0;
        rx_err     = 1'b0;
        case (rx_state_q)
            RX_IDLE: begin
                if (ps2_fall && !ps2_data_s2_q) begin
                    rx_state_d = RX_SHIFT;
                    bit_cnt_d  = '0;
                    timer_d    = TIMER_LOAD;
                end
            end
            RX_SHIFT: begin
                if (ps2_fall) begin
                    frame_d = {ps2_data_s2_q, frame_q[9:1]};
                    timer_d = TIMER_LOAD;
                    if (bit_cnt_q == 4'd9) begin
                        rx_state_d = RX_CHECK;
                        bit_cnt_d  = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end else if (timer_q == '0) begin
                    rx_state_d = RX_IDLE;
                    bit_cnt_d  = '0;
                    rx_err     = 1'b1;
                end else begin
                    timer_d = timer_q - TIMER_ONE;
                end
            end
            RX_CHECK: begin
                rx_state_d = RX_IDLE;
                // frame_q = {stop, parity, data[7:0]}
                if ((^frame_q[8:0]) && frame_q[9]) begin
                    frame_ok = 1'b1;
                end else begin
                    rx_err = 1'b1;
                end
            end
            default: rx_state_d = RX_IDLE;
        endcase
    end

    assign rx_byte       = frame_q[7:0];
    assign is_shift_code = (rx_byte == SC_LSHIFT) || (rx_byte == SC_RSHIFT);
    assign map           = scan_to_ascii(rx_byte, shift_flag_q);

    always_comb begin
        dec_state_d = dec_state_q;
        is_make     = 1'b0;
        is_release  = 1'b0;
        if (frame_ok) begin
            case (dec_state_q)
                D_NORM: begin
                    if (rx_byte == SC_BREAK) begin
                        dec_state_d = D_BREAK;
                    end else if (rx_byte == SC_EXT) begin
                        dec_state_d = D_EXT;
                    end else begin
                        is_make = 1'b1;
                    end
                end
                D_BREAK: begin
                    is_release  = 1'b1;
                    dec_state_d = D_NORM;
                end
                D_EXT: begin
                    dec_state_d = (rx_byte == SC_BREAK) ? D_EXT_BREAK : D_NORM;
                end
                D_EXT_BREAK: dec_state_d = D_NORM;
                default:     dec_state_d = D_NORM;
            endcase
        end
    end

`ifdef PS2_REPEAT_FILTER_EN
    logic [7:0] last_code_q, last_code_d;
    logic       last_valid_q, last_valid_d;

    assign repeat_hit = last_valid_q && (last_code_q == rx_byte);

    always_comb begin
        last_code_d  = last_code_q;
        last_valid_d = last_valid_q;
        if (is_make && !is_shift_code && !repeat_hit) begin
            last_code_d  = rx_byte;
            last_valid_d = 1'b1;
        end else if (is_release && repeat_hit) begin
            last_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            last_code_q  <= '0;
            last_valid_q <= 1'b0;
        end else begin
            last_code_q  <= last_code_d;
            last_valid_q <= last_valid_d;
        end
    end
`else
    assign repeat_hit = 1'b0;
`endif

    always_comb begin
        shift_flag_d = shift_flag_q;
        wr_en        = 1'b0;
        wr_data      = '0;
        if (is_make) begin
            if (is_shift_code) begin
                shift_flag_d = 1'b1;
            end else if (!repeat_hit && map.valid) begin
                wr_en   = 1'b1;
                wr_data = map.ascii;
            end
        end
        if (is_release && is_shift_code) begin
            shift_flag_d = 1'b0;
        end
        overflow_d  = fifo_ovf;
        frame_err_d = rx_err;
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            rx_state_q   <= RX_IDLE;
            bit_cnt_q    <= '0;
            frame_q      <= '0;
            timer_q      <= '0;
            dec_state_q  <= D_NORM;
            shift_flag_q <= 1'b0;
            overflow_q   <= 1'b0;
            frame_err_q  <= 1'b0;
        end else begin
            rx_state_q   <= rx_state_d;
            bit_cnt_q    <= bit_cnt_d;
            frame_q      <= frame_d;
            timer_q      <= timer_d;
            dec_state_q  <= dec_state_d;
            shift_flag_q <= shift_flag_d;
            overflow_q   <= overflow_d;
            frame_err_q  <= frame_err_d;
        end
    end

    ps2_ascii_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .clrn     (clrn),
        .wr_en    (wr_en),
        .wr_data  (wr_data),
        .rd_data  (key_ascii),
        .rd_valid (key_valid),
        .rd_ready (key_ready),
        .overflow (fifo_ovf)
    );

    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
